// File: rtl/ym3438_reg_wr_sched.sv
// ym3438_reg_wr_sched
//   Buffers CPU register writes in a small FIFO and releases each one to the
//   register file only in the operator/channel time slot it targets. The
//   24-slot sequencer runs 0-5 OP4, 6-11 OP1, 12-17 OP3, 18-23 OP2. The
//   channel number gives the offset inside each group.
//
// Ports
//   MCLK      master clock
//   IC        asynchronous active-low reset (initial clear)
//   slot_adv  one-MCLK strobe per sequencer slot
//   slot_idx  current slot number, valid while slot_adv=1
//   wr_req    push request; accepted when wr_ready=1
//   wr_part   register bank of the write (0: ch 0-2, 1: ch 3-5)
//   wr_addr   register address of the write
//   wr_data   register data of the write
//   wr_ready  FIFO not full
//   busy      FIFO non-empty or scheduler not idle
//   reg_we    one-MCLK commit strobe to the register file
//   reg_part  bank of the last commit
//   reg_addr  address of the last commit
//   reg_data  data of the last commit
//   reg_slot  slot the last commit was aligned to
//   drop_err  one-MCLK pulse when an entry is discarded
module ym3438_reg_wr_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic       MCLK,
  input  logic       IC,
  input  logic       slot_adv,
  input  logic [4:0] slot_idx,
  input  logic       wr_req,
  input  logic       wr_part,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       busy,
  output logic       reg_we,
  output logic       reg_part,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic [4:0] reg_slot,
  output logic       drop_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WAIT} state_t;

  state_t           state;
  logic [16:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [TMO_W-1:0] tmo_cnt;
  logic             push;
  logic             pop;

  // Entry held while waiting for its slot
  logic             ent_part;
  logic [7:0]       ent_addr;
  logic [7:0]       ent_data;
  logic             tgt_global;
  logic [4:0]       tgt_slot;

  // Head decode
  logic [16:0]      head;
  logic             hd_part;
  logic [7:0]       hd_addr;
  logic             hd_valid;
  logic             hd_global;
  logic [4:0]       hd_slot;
  logic [4:0]       hd_base;
  logic [2:0]       hd_ch;

  logic             match;
  logic             tmo_hit;

  // Full blocks a push even when a pop happens in the same cycle.
  assign wr_ready = (count != CNT_W'(DEPTH));
  assign push     = wr_req & wr_ready;
  assign busy     = (count != '0) | (state != S_IDLE);

  assign head    = mem[rd_ptr];
  assign hd_part = head[16];
  assign hd_addr = head[15:8];

  always_comb begin
    hd_valid  = 1'b0;
    hd_global = 1'b0;
    hd_slot   = '0;
    hd_ch     = (hd_part ? 3'd3 : 3'd0) + {1'b0, hd_addr[1:0]};
    case (hd_addr[3:2])
      2'd0:    hd_base = 5'd6;   // OP1
      2'd1:    hd_base = 5'd12;  // OP3
      2'd2:    hd_base = 5'd18;  // OP2
      default: hd_base = 5'd0;   // OP4
    endcase
    if (hd_addr[7:4] == 4'h2) begin
      // Global registers exist only in bank 0.
      hd_valid  = ~hd_part;
      hd_global = ~hd_part;
    end else if (hd_addr[1:0] != 2'd3) begin
      if (hd_addr >= 8'h30 && hd_addr <= 8'h9F) begin
        hd_valid = 1'b1;
        hd_slot  = hd_base + {2'b00, hd_ch};
      end else if (hd_addr >= 8'hA0 && hd_addr <= 8'hB6) begin
        hd_valid = 1'b1;
        hd_slot  = {2'b00, hd_ch};
      end
    end
  end

  assign match   = slot_adv & (tgt_global | (slot_idx == tgt_slot));
  assign tmo_hit = slot_adv & ~match & (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign pop     = ((state == S_DECODE) & ~hd_valid) |
                   ((state == S_WAIT) & (match | tmo_hit));

  always_ff @(posedge MCLK) begin
    if (push) mem[wr_ptr] <= {wr_part, wr_addr, wr_data};
  end

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head latch: captured during DECODE, consumed in WAIT
  always_ff @(posedge MCLK) begin
    if (state == S_DECODE) begin
      ent_part   <= hd_part;
      ent_addr   <= hd_addr;
      ent_data   <= head[7:0];
      tgt_global <= hd_global;
      tgt_slot   <= hd_slot;
    end
  end

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      state    <= S_IDLE;
      tmo_cnt  <= '0;
      reg_we   <= 1'b0;
      drop_err <= 1'b0;
      reg_part <= 1'b0;
      reg_addr <= '0;
      reg_data <= '0;
      reg_slot <= '0;
    end else begin
      reg_we   <= 1'b0;
      drop_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != '0) state <= S_DECODE;
        end
        S_DECODE: begin
          if (!hd_valid) begin
            drop_err <= 1'b1;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (match) begin
            reg_we   <= 1'b1;
            reg_part <= ent_part;
            reg_addr <= ent_addr;
            reg_data <= ent_data;
            reg_slot <= slot_idx;
            state    <= S_IDLE;
          end else if (tmo_hit) begin
            drop_err <= 1'b1;
            state    <= S_IDLE;
          end else if (slot_adv) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ym3438_reg_wr_sched.sv
module tb_ym3438_reg_wr_sched;

  logic       MCLK = 1'b0;
  logic       IC;
  logic       slot_adv;
  logic [4:0] slot_idx;
  logic       wr_req;
  logic       wr_part;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       busy;
  logic       reg_we;
  logic       reg_part;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic [4:0] reg_slot;
  logic       drop_err;

  always #5 MCLK = ~MCLK;

  ym3438_reg_wr_sched #(.DEPTH(4), .TIMEOUT(32)) dut (
    .MCLK     (MCLK),
    .IC       (IC),
    .slot_adv (slot_adv),
    .slot_idx (slot_idx),
    .wr_req   (wr_req),
    .wr_part  (wr_part),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .busy     (busy),
    .reg_we   (reg_we),
    .reg_part (reg_part),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .reg_slot (reg_slot),
    .drop_err (drop_err)
  );

  typedef struct {
    bit       drop;
    bit       glob;
    bit       part;
    bit [7:0] addr;
    bit [7:0] data;
    int       slot;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         passes = 0;
  int         seq_mode = 0;   // 0: no strobes, 1: sweep 0..23, 2: hold hold_idx
  int         hold_idx = 0;
  int         sweep = 0;
  int         seq_cnt = 0;
  logic       prev_adv = 1'b0;
  logic [4:0] prev_idx = '0;
  int         adv_seen = 0;
  int         drop_adv = 0;
  int         base_adv = 0;
  logic [7:0] t4a [5];
  int         r;
  bit         rp;
  logic [7:0] ra;
  logic [7:0] rd;

  // Reference: what the chip should do with a write, from the address map alone.
  function automatic exp_t model(input bit p, input bit [7:0] a, input bit [7:0] d);
    exp_t e;
    int   ch;
    int   op;
    e.drop = 1'b1;
    e.glob = 1'b0;
    e.part = p;
    e.addr = a;
    e.data = d;
    e.slot = 0;
    ch = (p ? 3 : 0) + (a % 4);
    if (a >= 8'h20 && a <= 8'h2F) begin
      if (!p) begin
        e.drop = 1'b0;
        e.glob = 1'b1;
      end
    end else if ((a % 4) != 3) begin
      if (a >= 8'h30 && a <= 8'h9F) begin
        op = (a / 4) % 4;  // 0:OP1 1:OP3 2:OP2 3:OP4
        e.slot = (op == 3) ? ch : 6 * (op + 1) + ch;
        e.drop = 1'b0;
      end else if (a >= 8'hA0 && a <= 8'hB6) begin
        e.slot = ch;
        e.drop = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: actual %0d required %0d", nm, act, req);
  endtask

  always @(posedge MCLK) begin
    prev_adv <= slot_adv;
    prev_idx <= slot_idx;
    if (slot_adv) adv_seen <= adv_seen + 1;
  end

  // Monitor / scoreboard
  always @(negedge MCLK) begin
    exp_t e;
    if (IC === 1'b1) begin
      if (reg_we || drop_err) chk("we_drop_exclusive", int'(reg_we & drop_err), 0);
      if (reg_we) begin
        if (sb.size() == 0) chk("unexpected_reg_we_queue", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("commit_kind", int'(e.drop), 0);
          chk("reg_part", int'(reg_part), int'(e.part));
          chk("reg_addr", int'(reg_addr), int'(e.addr));
          chk("reg_data", int'(reg_data), int'(e.data));
          if (!e.glob) chk("reg_slot", int'(reg_slot), e.slot);
          chk("adv_before_we", int'(prev_adv), 1);
          chk("slot_at_adv", int'(reg_slot), int'(prev_idx));
        end
      end
      if (drop_err) begin
        drop_adv = adv_seen;
        if (sb.size() == 0) chk("unexpected_drop_queue", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("drop_kind", int'(e.drop), 1);
        end
      end
    end
  end

  // Slot sequencer
  initial begin
    slot_adv = 1'b0;
    slot_idx = '0;
    forever begin
      @(negedge MCLK);
      seq_cnt++;
      if (seq_mode != 0 && (seq_cnt % 3) == 0) begin
        slot_adv = 1'b1;
        if (seq_mode == 1) begin
          slot_idx = 5'(sweep);
          sweep = (sweep + 1) % 24;
        end else begin
          slot_idx = 5'(hold_idx);
        end
      end else begin
        slot_adv = 1'b0;
      end
    end
  end

  task automatic push(input bit p, input bit [7:0] a, input bit [7:0] d);
    int n = 0;
    while (wr_ready !== 1'b1 && n < 400) begin
      @(negedge MCLK);
      n++;
    end
    chk("push_ready", int'(wr_ready), 1);
    if (wr_ready !== 1'b1) return;
    wr_req  = 1'b1;
    wr_part = p;
    wr_addr = a;
    wr_data = d;
    sb.push_back(model(p, a, d));
    @(negedge MCLK);
    wr_req = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge MCLK);
      n++;
    end
    @(negedge MCLK);
    @(negedge MCLK);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_queue_empty"}, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1);
  end

  initial begin
    IC      = 1'b0;
    wr_req  = 1'b0;
    wr_part = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    t4a     = '{8'h30, 8'h45, 8'hA2, 8'h6A, 8'h50};
    repeat (3) @(negedge MCLK);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_reg_we", int'(reg_we), 0);
    chk("rst_drop_err", int'(drop_err), 0);
    chk("rst_reg_addr", int'(reg_addr), 0);
    chk("rst_reg_slot", int'(reg_slot), 0);
    IC = 1'b1;
    @(negedge MCLK);

    // T1: operator register lands in OP1 slot of channel 0
    seq_mode = 1;
    push(1'b0, 8'h30, 8'h71);
    wait_idle("t1", 300);
    chk("t1_reg_slot", int'(reg_slot), 6);

    // T2: channel register, bank 1, ch 4
    push(1'b1, 8'hA5, 8'h3C);
    wait_idle("t2", 300);
    chk("t2_reg_slot", int'(reg_slot), 4);

    // T3: global register commits on whatever slot comes next
    hold_idx = 17;
    seq_mode = 2;
    push(1'b0, 8'h28, 8'h5A);
    wait_idle("t3", 100);
    chk("t3_reg_slot", int'(reg_slot), 17);

    // T4: fill the FIFO with no strobes running, fifth push refused
    seq_mode = 0;
    repeat (3) @(negedge MCLK);
    for (int i = 0; i < 5; i++) begin
      chk("t4_wr_ready", int'(wr_ready), (i < 4) ? 1 : 0);
      wr_req  = 1'b1;
      wr_part = i[0];
      wr_addr = t4a[i];
      wr_data = 8'(8'h10 + i);
      if (wr_ready === 1'b1) sb.push_back(model(i[0], t4a[i], 8'(8'h10 + i)));
      @(negedge MCLK);
    end
    wr_req = 1'b0;
    seq_mode = 1;
    wait_idle("t4", 600);

    // T5: invalid addresses are dropped
    push(1'b1, 8'h2A, 8'h01);
    push(1'b0, 8'h33, 8'h02);
    wait_idle("t5", 100);

    // T6: slot 31 never matches, entry times out after 32 strobes
    seq_mode = 0;
    repeat (3) @(negedge MCLK);
    push(1'b0, 8'h30, 8'h99);
    sb[sb.size() - 1].drop = 1'b1;
    repeat (4) @(negedge MCLK);
    base_adv = adv_seen;
    hold_idx = 31;
    seq_mode = 2;
    wait_idle("t6_tmo", 300);
    chk("t6_strobes_to_drop", drop_adv - base_adv, 32);

    // T6: reset while an entry waits
    push(1'b0, 8'h30, 8'h11);
    repeat (10) @(negedge MCLK);
    chk("t6_busy_before_ic", int'(busy), 1);
    IC = 1'b0;
    sb.delete();
    #1;
    chk("t6_ic_busy", int'(busy), 0);
    chk("t6_ic_wr_ready", int'(wr_ready), 1);
    chk("t6_ic_reg_we", int'(reg_we), 0);
    chk("t6_ic_reg_addr", int'(reg_addr), 0);
    chk("t6_ic_reg_data", int'(reg_data), 0);
    chk("t6_ic_reg_slot", int'(reg_slot), 0);
    @(negedge MCLK);
    IC = 1'b1;
    repeat (120) @(negedge MCLK);
    chk("t6_after_ic_busy", int'(busy), 0);

    // Randomized traffic with a continuous slot sweep
    seq_mode = 1;
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge MCLK);
      r  = int'($urandom_range(0, 9));
      rp = 1'($urandom_range(0, 1));
      rd = 8'($urandom_range(0, 255));
      if (r <= 4) ra = 8'(8'h30 + $urandom_range(0, 8'h6F));
      else if (r <= 6) ra = 8'(8'hA0 + $urandom_range(0, 22));
      else if (r == 7) begin
        rp = 1'b0;
        ra = 8'(8'h20 + 4 * $urandom_range(0, 3) + $urandom_range(0, 2));
      end else if (r == 8) begin
        if ($urandom_range(0, 1) == 1) ra = 8'($urandom_range(0, 31));
        else ra = 8'($urandom_range(8'hB7, 8'hFF));
      end else begin
        rp = 1'b1;
        ra = 8'(8'h20 + $urandom_range(0, 15));
      end
      push(rp, ra, rd);
    end
    wait_idle("rand", 3000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
